// File: rtl/row_buf_ring.sv
`default_nettype none
// ==========================================================================================
// row_buf_ring : N-line circular row buffer returning vertically adjacent pixel pairs. Rev 1.0
// ==========================================================================================
module row_buf_ring #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 10,
   parameter int MAX_W   = 640,
   parameter int N_LINES = 4,
   parameter int LP_W    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic [ADDR_W-1:0] width,
   input  logic [DATA_W-1:0] data_in,
   input  logic              in_data_en,
   output logic              in_ready,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_row_addr,
   input  logic              rd_pop,
   output logic [DATA_W-1:0] top_pix_out,
   output logic [DATA_W-1:0] bot_pix_out,
   output logic              out_valid,
   output logic [LP_W:0]     lines_avail,
   output logic              err_flag
);

   localparam logic [ADDR_W:0]   MAX_W_C = (ADDR_W+1)'(MAX_W);
   localparam logic [ADDR_W:0]   W_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] COL_ONE = ADDR_W'(1);
   localparam logic [LP_W-1:0]   LP_ONE  = LP_W'(1);
   localparam logic [LP_W:0]     AV_ONE  = (LP_W+1)'(1);
   localparam logic [LP_W:0]     AV_TWO  = (LP_W+1)'(2);
   localparam logic [LP_W:0]     AV_FULL = (LP_W+1)'(N_LINES);

   logic [ADDR_W:0]   width_q, width_d;
   logic [ADDR_W-1:0] wr_col_q, wr_col_d;
   logic [LP_W-1:0]   wr_lp_q, wr_lp_d;
   logic [LP_W-1:0]   rd_lp_q, rd_lp_d;
   logic [LP_W:0]     avail_q, avail_d;
   logic              err_q, err_d;
   logic              wv_q, wv_d;
   logic              wlast_q, wlast_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] wcol_q, wcol_d;
   logic [LP_W-1:0]   wlp_q, wlp_d;
   logic              s1_vld_q, s1_vld_d;
   logic [LP_W-1:0]   s1_top_lp_q, s1_top_lp_d;
   logic [LP_W-1:0]   s1_bot_lp_q, s1_bot_lp_d;
   logic [ADDR_W-1:0] s1_col_q, s1_col_d;
   logic              out_vld_q, out_vld_d;
   logic [DATA_W-1:0] top_q, top_d;
   logic [DATA_W-1:0] bot_q, bot_d;

   logic [DATA_W-1:0] mem [N_LINES][MAX_W];

   logic              accept;
   logic              wr_fire;
   logic              line_done;
   logic              pop_ok;
   logic              rd_ok;
   logic              col_last;
   logic [ADDR_W:0]   width_m1;
   logic [ADDR_W-1:0] rd_col;

   assign in_ready  = (avail_q != AV_FULL);
   assign accept    = in_data_en && in_ready && !frame_start;
   // frame_start discards a pixel still sitting in the write register
   assign wr_fire   = wv_q && !frame_start;
   assign line_done = wr_fire && wlast_q;
   assign pop_ok    = rd_pop && (avail_q != '0) && !frame_start;
   assign rd_ok     = rd_en && (avail_q >= AV_TWO) && !frame_start;
   assign width_m1  = width_q - W_ONE;
   assign col_last  = ({1'b0, wr_col_q} == width_m1);
   assign rd_col    = ({1'b0, rd_row_addr} >= width_q) ? width_m1[ADDR_W-1:0] : rd_row_addr;

   always_comb begin
      width_d     = width_q;
      wr_col_d    = wr_col_q;
      wr_lp_d     = wr_lp_q;
      rd_lp_d     = rd_lp_q;
      avail_d     = avail_q;
      err_d       = err_q;
      wv_d        = 1'b0;
      wlast_d     = wlast_q;
      wdata_d     = wdata_q;
      wcol_d      = wcol_q;
      wlp_d       = wlp_q;
      s1_vld_d    = 1'b0;
      s1_top_lp_d = s1_top_lp_q;
      s1_bot_lp_d = s1_bot_lp_q;
      s1_col_d    = s1_col_q;
      out_vld_d   = 1'b0;
      top_d       = top_q;
      bot_d       = bot_q;

      if (frame_start) begin
         width_d  = ((width == '0) || ({1'b0, width} > MAX_W_C)) ? MAX_W_C : {1'b0, width};
         wr_col_d = '0;
         wr_lp_d  = '0;
         rd_lp_d  = '0;
         avail_d  = '0;
         err_d    = 1'b0;
      end else begin
         wv_d = accept;
         if (accept) begin
            wdata_d = data_in;
            wcol_d  = wr_col_q;
            wlp_d   = wr_lp_q;
            wlast_d = col_last;
            if (col_last) begin
               wr_col_d = '0;
               wr_lp_d  = wr_lp_q + LP_ONE;
            end else begin
               wr_col_d = wr_col_q + COL_ONE;
            end
         end

         if (pop_ok) begin
            rd_lp_d = rd_lp_q + LP_ONE;
         end
         if (line_done && !pop_ok) begin
            avail_d = avail_q + AV_ONE;
         end else if (pop_ok && !line_done) begin
            avail_d = avail_q - AV_ONE;
         end

         err_d = err_q | (in_data_en && !in_ready) | (rd_en && (avail_q < AV_TWO))
               | (rd_pop && (avail_q == '0));

         // the issuing cycle's rd_lp is captured, so a same-cycle pop does not disturb it
         s1_vld_d = rd_ok;
         if (rd_ok) begin
            s1_col_d    = rd_col;
            s1_top_lp_d = rd_lp_q;
            s1_bot_lp_d = rd_lp_q + LP_ONE;
         end

         out_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            top_d = mem[s1_top_lp_q][s1_col_q];
            bot_d = mem[s1_bot_lp_q][s1_col_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wlp_q][wcol_q] <= wdata_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         width_q     <= MAX_W_C;
         wr_col_q    <= '0;
         wr_lp_q     <= '0;
         rd_lp_q     <= '0;
         avail_q     <= '0;
         err_q       <= 1'b0;
         wv_q        <= 1'b0;
         wlast_q     <= 1'b0;
         wdata_q     <= '0;
         wcol_q      <= '0;
         wlp_q       <= '0;
         s1_vld_q    <= 1'b0;
         s1_top_lp_q <= '0;
         s1_bot_lp_q <= '0;
         s1_col_q    <= '0;
         out_vld_q   <= 1'b0;
         top_q       <= '0;
         bot_q       <= '0;
      end else begin
         width_q     <= width_d;
         wr_col_q    <= wr_col_d;
         wr_lp_q     <= wr_lp_d;
         rd_lp_q     <= rd_lp_d;
         avail_q     <= avail_d;
         err_q       <= err_d;
         wv_q        <= wv_d;
         wlast_q     <= wlast_d;
         wdata_q     <= wdata_d;
         wcol_q      <= wcol_d;
         wlp_q       <= wlp_d;
         s1_vld_q    <= s1_vld_d;
         s1_top_lp_q <= s1_top_lp_d;
         s1_bot_lp_q <= s1_bot_lp_d;
         s1_col_q    <= s1_col_d;
         out_vld_q   <= out_vld_d;
         top_q       <= top_d;
         bot_q       <= bot_d;
      end
   end

   assign top_pix_out = top_q;
   assign bot_pix_out = bot_q;
   assign out_valid   = out_vld_q;
   assign lines_avail = avail_q;
   assign err_flag    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_row_buf_ring.sv
`default_nettype none
// tb_row_buf_ring : cycle model + scoreboard bench for row_buf_ring.
module tb_row_buf_ring;

   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 10;
   localparam int MAX_W   = 640;
   localparam int N_LINES = 4;
   localparam int LP_W    = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              frame_start = 1'b0;
   logic [ADDR_W-1:0] width = '0;
   logic [DATA_W-1:0] data_in = '0;
   logic              in_data_en = 1'b0;
   logic              in_ready;
   logic              rd_en = 1'b0;
   logic [ADDR_W-1:0] rd_row_addr = '0;
   logic              rd_pop = 1'b0;
   logic [DATA_W-1:0] top_pix_out;
   logic [DATA_W-1:0] bot_pix_out;
   logic              out_valid;
   logic [LP_W:0]     lines_avail;
   logic              err_flag;

   row_buf_ring #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .MAX_W  (MAX_W),
      .N_LINES(N_LINES),
      .LP_W   (LP_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_start(frame_start),
      .width      (width),
      .data_in    (data_in),
      .in_data_en (in_data_en),
      .in_ready   (in_ready),
      .rd_en      (rd_en),
      .rd_row_addr(rd_row_addr),
      .rd_pop     (rd_pop),
      .top_pix_out(top_pix_out),
      .bot_pix_out(bot_pix_out),
      .out_valid  (out_valid),
      .lines_avail(lines_avail),
      .err_flag   (err_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] top;
      logic [7:0] bot;
      int         cyc;
   } sb_t;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         exp_w = MAX_W;
   int         exp_avail = 0;
   int         wr_line = 0;
   int         wr_col_m = 0;
   int         rd_line = 0;
   bit         pend = 1'b0;
   bit         exp_err = 1'b0;
   bit         mon_en = 1'b0;
   logic [7:0] last_top = '0;
   logic [7:0] last_bot = '0;
   logic [7:0] mdl [16][MAX_W];
   sb_t        sb_q[$];
   sb_t        got;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pval(input int line, input int col);
      return 8'(line * exp_w + col + ((exp_w > 64) ? line * 11 : 0));
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle model: decide from the inputs before the edge, commit after it.
   task automatic tick();
      bit  fs, acc, pop_ok, rd_ok, done, err_n;
      int  c, w_n;
      sb_t e;
      fs     = frame_start;
      w_n    = ((width == '0) || (int'(width) > MAX_W)) ? MAX_W : int'(width);
      done   = pend;
      acc    = in_data_en && (exp_avail != N_LINES);
      pop_ok = rd_pop && (exp_avail > 0);
      rd_ok  = rd_en && (exp_avail >= 2);
      err_n  = exp_err || (in_data_en && exp_avail == N_LINES) || (rd_en && exp_avail < 2)
               || (rd_pop && exp_avail == 0);
      e.top  = '0;
      e.bot  = '0;
      e.cyc  = 0;
      if (rd_ok && !fs) begin
         c     = (int'(rd_row_addr) >= exp_w) ? exp_w - 1 : int'(rd_row_addr);
         e.top = mdl[rd_line % 16][c];
         e.bot = mdl[(rd_line + 1) % 16][c];
      end
      if (acc && !fs) mdl[wr_line % 16][wr_col_m] = data_in;
      @(posedge clk);
      #1;
      if (fs) begin
         exp_w     = w_n;
         exp_avail = 0;
         wr_line   = 0;
         wr_col_m  = 0;
         rd_line   = 0;
         pend      = 1'b0;
         exp_err   = 1'b0;
         sb_q.delete();
      end else begin
         pend = 1'b0;
         if (acc) begin
            wr_col_m++;
            if (wr_col_m == exp_w) begin
               wr_col_m = 0;
               wr_line++;
               pend = 1'b1;
            end
         end
         exp_avail = exp_avail + int'(done) - int'(pop_ok);
         rd_line   = rd_line + int'(pop_ok);
         exp_err   = err_n;
         if (rd_ok) begin
            e.cyc = cyc;
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic frame(input int w);
      frame_start = 1'b1;
      width       = ADDR_W'(w);
      tick();
      frame_start = 1'b0;
   endtask

   task automatic send(input int n);
      for (int i = 0; i < n; i++) begin
         data_in    = pval(wr_line, wr_col_m);
         in_data_en = 1'b1;
         tick();
      end
      in_data_en = 1'b0;
   endtask

   task automatic pop();
      rd_pop = 1'b1;
      tick();
      rd_pop = 1'b0;
   endtask

   task automatic reads(input int c0, input int c1, input int c2, input int c3);
      int cols[4];
      cols = '{c0, c1, c2, c3};
      for (int i = 0; i < 4; i++) begin
         rd_en       = 1'b1;
         rd_row_addr = ADDR_W'(cols[i]);
         tick();
      end
      rd_en = 1'b0;
   endtask

   task automatic drain();
      repeat (3) tick();
      check("sb_drained", sb_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         check("lines_avail", lines_avail, exp_avail);
         check("in_ready", in_ready, exp_avail != N_LINES);
         check("err_flag", err_flag, exp_err);
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               check("spurious_valid", out_valid, 1'b0);
            end else begin
               got = sb_q.pop_front();
               check("top_pix", top_pix_out, got.top);
               check("bot_pix", bot_pix_out, got.bot);
               check("latency", cyc - got.cyc, 1);
            end
            last_top = top_pix_out;
            last_bot = bot_pix_out;
         end else begin
            check("top_hold", top_pix_out, last_top);
            check("bot_hold", bot_pix_out, last_bot);
            if (sb_q.size() > 0 && (cyc - sb_q[0].cyc) >= 1) begin
               check("missing_valid", out_valid, 1'b1);
               got = sb_q.pop_front();
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_avail", lines_avail, 0);
      check("rst_ready", in_ready, 1'b1);
      check("rst_valid", out_valid, 1'b0);
      check("rst_err", err_flag, 1'b0);
      check("rst_top", top_pix_out, 0);
      check("rst_bot", bot_pix_out, 0);
      @(posedge clk);
      #1 mon_en = 1'b1;

      // two lines of width 4, pixels 0..7, read back all columns
      frame(4);
      send(8);
      tick();
      check("t1_avail", lines_avail, 2);
      reads(0, 1, 2, 3);
      drain();

      // out-of-range column clamps; read with a single line is rejected
      reads(9, 9, 3, 1000);
      drain();
      pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      drain();
      check("t3_err", err_flag, 1'b1);

      // fill all slots, overflow pixel dropped, pop reopens input
      frame(4);
      check("t2_err_clr", err_flag, 1'b0);
      send(16);
      tick();
      check("t2_full_ready", in_ready, 1'b0);
      check("t2_full_avail", lines_avail, 4);
      send(1);
      check("t2_drop_err", err_flag, 1'b1);
      pop();
      check("t2_pop_ready", in_ready, 1'b1);
      check("t2_pop_avail", lines_avail, 3);
      reads(0, 1, 2, 3);
      drain();

      // completion and pop on the same edge
      frame(4);
      send(8);
      tick();
      send(4);
      pop();
      check("t4_avail", lines_avail, 2);
      reads(0, 3, 2, 7);
      drain();

      // full-width lines wrapping both pointers over 10 lines
      frame(0);
      for (int l = 0; l < 10; l++) begin
         send(MAX_W);
         tick();
         if (exp_avail >= 2) begin
            reads(0, 320, 639, 1000);
            pop();
         end
      end
      drain();

      // frame_start mid-line with a read in flight and a pixel in the write register
      frame(4);
      send(8);
      tick();
      rd_en       = 1'b1;
      rd_row_addr = '0;
      send(1);
      rd_en = 1'b0;
      frame(2);
      check("t6_avail", lines_avail, 0);
      check("t6_valid", out_valid, 1'b0);
      check("t6_ready", in_ready, 1'b1);
      send(4);
      tick();
      reads(0, 1, 5, 0);
      drain();

      // asynchronous reset mid-operation
      send(3);
      rd_en       = 1'b1;
      rd_row_addr = 10'd1;
      tick();
      rd_en = 1'b0;
      #2 rst_n = 1'b0;
      mon_en = 1'b0;
      #1;
      check("t6r_avail", lines_avail, 0);
      check("t6r_ready", in_ready, 1'b1);
      check("t6r_valid", out_valid, 1'b0);
      check("t6r_err", err_flag, 1'b0);
      check("t6r_top", top_pix_out, 0);
      exp_w     = MAX_W;
      exp_avail = 0;
      wr_line   = 0;
      wr_col_m  = 0;
      rd_line   = 0;
      pend      = 1'b0;
      exp_err   = 1'b0;
      last_top  = '0;
      last_bot  = '0;
      sb_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1'b1;
      pop();
      check("pop_empty_err", err_flag, 1'b1);
      frame(2);
      send(4);
      tick();
      reads(1, 0, 2, 1);
      drain();

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
